// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master slice: FSM states, slave
// indices and default address map / timeout.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  typedef logic [1:0] slv_idx_t;

  // Index values double as bit positions in the per-slave select vector.
  localparam slv_idx_t SLV_UART = 2'd0;
  localparam slv_idx_t SLV_GPIO = 2'd1;
  localparam slv_idx_t SLV_NONE = 2'd2;

  localparam logic [19:0] DEF_UART_BASE = 20'h00000;
  localparam logic [19:0] DEF_GPIO_BASE = 20'h00001;
  localparam int          DEF_TIMEOUT   = 16;

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps the 4 KiB page of a request address (addr[31:12]) to a slave index;
// pages that match no slave decode to SLV_NONE.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter logic [19:0] UART_BASE = DEF_UART_BASE,
  parameter logic [19:0] GPIO_BASE = DEF_GPIO_BASE
) (
  input  logic [19:0] page,
  output slv_idx_t    slv
);

  always_comb begin
    slv = SLV_NONE;
    if (page == UART_BASE) begin
      slv = SLV_UART;
    end else if (page == GPIO_BASE) begin
      slv = SLV_GPIO;
    end
  end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: valid/ready command in, SETUP/ACCESS transfer
// to the UART or GPIO slave, one-cycle response pulse with data or error out.
module apb_master
  import apb_pkg::*;
#(
  parameter logic [19:0] UART_BASE = DEF_UART_BASE,
  parameter logic [19:0] GPIO_BASE = DEF_GPIO_BASE,
  parameter int          TIMEOUT   = DEF_TIMEOUT
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PSEL_UART,
  output logic        PSEL_GPIO,
  output logic        PENABLE,
  input  logic [31:0] PRDATA_UART,
  input  logic [31:0] PRDATA_GPIO,
  input  logic        PREADY_UART,
  input  logic        PREADY_GPIO
);

  localparam int NUM_SLV = 2;
  // The counter only needs to reach TIMEOUT-1 before the abort fires.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_t       state_reg, state_next;
  slv_idx_t         slv_reg, slv_next, dec_slv;
  logic [31:0]      paddr_reg, paddr_next;
  logic [31:0]      pwdata_reg, pwdata_next;
  logic             pwrite_reg, pwrite_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [31:0]      rsp_rdata_reg, rsp_rdata_next;
  logic             rsp_error_reg, rsp_error_next;

  logic               bus_active;
  logic [NUM_SLV-1:0] psel_vec;
  logic [NUM_SLV-1:0] pready_vec;
  logic [31:0]        prdata_arr   [NUM_SLV];
  logic [31:0]        prdata_gated [NUM_SLV];
  logic               pready_mux;
  logic [31:0]        prdata_mux;

  apb_addr_decoder #(
    .UART_BASE (UART_BASE),
    .GPIO_BASE (GPIO_BASE)
  ) u_dec (
    .page (req_addr[31:12]),
    .slv  (dec_slv)
  );

  assign bus_active    = (state_reg == SETUP) || (state_reg == ACCESS);
  assign prdata_arr[0] = PRDATA_UART;
  assign prdata_arr[1] = PRDATA_GPIO;
  assign pready_vec    = {PREADY_GPIO, PREADY_UART};

  // Select and return-path gating share the latched slave index, so only the
  // addressed slave can ever complete or feed data into a transfer.
  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
    assign psel_vec[gi]     = bus_active && (slv_reg == slv_idx_t'(gi));
    assign prdata_gated[gi] = psel_vec[gi] ? prdata_arr[gi] : '0;
  end

  assign pready_mux = |(pready_vec & psel_vec);
  assign prdata_mux = prdata_gated[0] | prdata_gated[1];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg     <= IDLE;
      slv_reg       <= SLV_NONE;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      pwrite_reg    <= 1'b0;
      wait_cnt_reg  <= '0;
      rsp_rdata_reg <= '0;
      rsp_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      slv_reg       <= slv_next;
      paddr_reg     <= paddr_next;
      pwdata_reg    <= pwdata_next;
      pwrite_reg    <= pwrite_next;
      wait_cnt_reg  <= wait_cnt_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_error_reg <= rsp_error_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    slv_next       = slv_reg;
    paddr_next     = paddr_reg;
    pwdata_next    = pwdata_reg;
    pwrite_next    = pwrite_reg;
    wait_cnt_next  = '0;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_error_next = rsp_error_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          paddr_next  = req_addr;
          pwdata_next = req_wdata;
          pwrite_next = req_write;
          slv_next    = dec_slv;
          if (dec_slv == SLV_NONE) begin
            rsp_error_next = 1'b1;
            rsp_rdata_next = '0;
            state_next     = RESP;
          end else begin
            state_next = SETUP;
          end
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (pready_mux) begin
          rsp_rdata_next = pwrite_reg ? '0 : prdata_mux;
          rsp_error_next = 1'b0;
          state_next     = RESP;
        end else if ((TIMEOUT != 0) && (wait_cnt_reg == CNT_LAST)) begin
          rsp_rdata_next = '0;
          rsp_error_next = 1'b1;
          state_next     = RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_error = rsp_error_reg;
  assign PADDR     = paddr_reg;
  assign PWDATA    = pwdata_reg;
  assign PWRITE    = pwrite_reg;
  assign PENABLE   = (state_reg == ACCESS);
  assign PSEL_UART = psel_vec[0];
  assign PSEL_GPIO = psel_vec[1];

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed vector table, hand sequences
// for back-to-back and mid-transfer reset, then randomized commands vs a model.
module tb_apb_master;

  localparam int TO = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA;
  logic        PWRITE, PSEL_UART, PSEL_GPIO, PENABLE;
  logic [31:0] PRDATA_UART, PRDATA_GPIO;
  logic        PREADY_UART, PREADY_GPIO;

  int n_checks = 0;
  int n_fail   = 0;
  int txn_no   = 0;

  apb_master #(
    .UART_BASE (20'h00000),
    .GPIO_BASE (20'h00001),
    .TIMEOUT   (TO)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PWRITE      (PWRITE),
    .PSEL_UART   (PSEL_UART),
    .PSEL_GPIO   (PSEL_GPIO),
    .PENABLE     (PENABLE),
    .PRDATA_UART (PRDATA_UART),
    .PRDATA_GPIO (PRDATA_GPIO),
    .PREADY_UART (PREADY_UART),
    .PREADY_GPIO (PREADY_GPIO)
  );

  always #5 PCLK = ~PCLK;

  // Slave model: raise PREADY after cfg_waits ACCESS cycles of the selected slave.
  int          cfg_waits = 0;
  logic [31:0] cfg_rd_u = '0;
  logic [31:0] cfg_rd_g = '0;
  int          acc_cnt;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)     acc_cnt <= 0;
    else if (PENABLE) acc_cnt <= acc_cnt + 1;
    else              acc_cnt <= 0;
  end

  assign PREADY_UART = PSEL_UART && PENABLE && (acc_cnt >= cfg_waits);
  assign PREADY_GPIO = PSEL_GPIO && PENABLE && (acc_cnt >= cfg_waits);
  assign PRDATA_UART = cfg_rd_u;
  assign PRDATA_GPIO = cfg_rd_g;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rd_u;
    logic [31:0] rd_g;
    int          sel;    // 0 none, 1 UART, 2 GPIO
    int          lat;    // cycles from acceptance edge to rsp_valid
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Reference: outcome of one command from the address map and slave wait count.
  function automatic void model(input logic wr, input logic [31:0] addr, input int waits,
                                input logic [31:0] ru, input logic [31:0] rg,
                                output int sel, output int lat, output logic err,
                                output logic [31:0] rdata);
    if (addr[31:12] == 20'h00000)      sel = 1;
    else if (addr[31:12] == 20'h00001) sel = 2;
    else                               sel = 0;
    if (sel == 0) begin
      lat = 1; err = 1'b1; rdata = '0;
    end else if (waits < TO) begin
      lat = 3 + waits; err = 1'b0;
      rdata = wr ? 32'h0 : ((sel == 1) ? ru : rg);
    end else begin
      lat = 2 + TO; err = 1'b1; rdata = '0;
    end
  endfunction

  task automatic run_cmd(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int waits,
                         input logic [31:0] ru, input logic [31:0] rg,
                         input int esel, input int elat, input logic eerr,
                         input logic [31:0] erd);
    int n;
    logic [4:0] eb;
    cfg_waits = waits; cfg_rd_u = ru; cfg_rd_g = rg;
    req_write = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk({tag, ".ready"}, 128'(req_ready), 128'(1'b1));
    tick();
    // Scramble the request after acceptance: the bus must keep the latched copy.
    req_valid = 1'b0; req_write = ~wr; req_addr = $urandom; req_wdata = $urandom;
    for (n = 1; n <= elat; n++) begin
      eb = {(esel == 1) && (n < elat), (esel == 2) && (n < elat),
            (esel != 0) && (n >= 2) && (n < elat), n == elat, 1'b0};
      chk({tag, ".bus"}, 128'({PSEL_UART, PSEL_GPIO, PENABLE, rsp_valid, req_ready}), 128'(eb));
      if (esel != 0 && n < elat)
        chk({tag, ".fields"}, 128'({PADDR, PWDATA, PWRITE}), 128'({addr, wd, wr}));
      if (n == elat)
        chk({tag, ".rsp"}, 128'({rsp_error, rsp_rdata}), 128'({eerr, erd}));
      tick();
    end
    chk({tag, ".idle"}, 128'({PSEL_UART, PSEL_GPIO, PENABLE, rsp_valid, req_ready}), 128'(5'b00001));
    chk({tag, ".hold"}, 128'({rsp_error, rsp_rdata}), 128'({eerr, erd}));
    n = 0;
    while (!req_ready && n < 60) begin tick(); n++; end
    txn_no++;
    $display("txn %0d %s wr=%0b addr=%h wdata=%h waits=%0d -> err=%0b rdata=%h lat=%0d",
             txn_no, tag, wr, addr, wd, waits, rsp_error, rsp_rdata, elat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, required end of test before it", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int sel, lat, w, kind;
    logic e, wr;
    logic [31:0] a, wd, r, ru, rg;

    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0000_00AA, 0,    32'h1111_1111, 32'h2222_2222, 1, 3,  1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_1004, 32'h0,         3,    32'h1111_1111, 32'h1234_5678, 2, 6,  1'b0, 32'h1234_5678};
    vecs[2]  = '{1'b0, 32'h0000_5000, 32'h0,         0,    32'h1111_1111, 32'h2222_2222, 0, 1,  1'b1, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0010, 32'h5555_0000, 1000, 32'h1111_1111, 32'h2222_2222, 1, 18, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0FFC, 32'h0,         0,    32'hDEAD_BEEF, 32'h2222_2222, 1, 3,  1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b0, 32'h0000_1000, 32'h0,         15,   32'h1111_1111, 32'h0BAD_F00D, 2, 18, 1'b0, 32'h0BAD_F00D};
    vecs[6]  = '{1'b1, 32'h0000_1FFC, 32'h7777_7777, 16,   32'h1111_1111, 32'h2222_2222, 2, 18, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_1008, 32'h0,         1,    32'h1111_1111, 32'hA5A5_0001, 2, 4,  1'b0, 32'hA5A5_0001};
    vecs[8]  = '{1'b0, 32'h0000_2000, 32'h0,         0,    32'h1111_1111, 32'h2222_2222, 0, 1,  1'b1, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0004, 32'hCAFE_CAFE, 2,    32'h9999_9999, 32'h2222_2222, 1, 5,  1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'hFFFF_F000, 32'h0,         0,    32'h1111_1111, 32'h2222_2222, 0, 1,  1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_0100, 32'h0,         14,   32'h3C3C_3C3C, 32'h2222_2222, 1, 17, 1'b0, 32'h3C3C_3C3C};

    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_state", 128'({req_ready, rsp_valid, rsp_error, rsp_rdata, PADDR, PWDATA,
                             PWRITE, PSEL_UART, PSEL_GPIO, PENABLE}),
        128'({1'b1, 102'b0}));
    PRESETn = 1'b1;
    tick();

    for (int i = 0; i < 12; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
              vecs[i].rd_u, vecs[i].rd_g, vecs[i].sel, vecs[i].lat, vecs[i].err, vecs[i].rdata);

    // Back-to-back: second command presented while the first is in flight.
    cfg_waits = 0; cfg_rd_u = 32'h1111_1111; cfg_rd_g = 32'hCAFE_0001;
    req_write = 1'b1; req_addr = 32'h0000_0010; req_wdata = 32'h1; req_valid = 1'b1;
    chk("b2b.ready", 128'(req_ready), 128'(1'b1));
    tick();
    req_write = 1'b0; req_addr = 32'h0000_1008; req_wdata = 32'h2;
    for (int k = 1; k <= 3; k++) begin
      chk("b2b.first_fields", 128'({PADDR, PWDATA, PWRITE}), 128'({32'h10, 32'h1, 1'b1}));
      tick();
    end
    chk("b2b.ready_k4", 128'({req_ready, PADDR}), 128'({1'b1, 32'h10}));
    tick();
    chk("b2b.second_setup", 128'({PSEL_UART, PSEL_GPIO, PENABLE, PADDR, PWRITE}),
        128'({1'b0, 1'b1, 1'b0, 32'h1008, 1'b0}));
    req_valid = 1'b0;
    n = 5;
    while (!rsp_valid && n < 30) begin tick(); n++; end
    chk("b2b.rsp", 128'({n, rsp_error, rsp_rdata}), 128'({32'd7, 1'b0, 32'hCAFE_0001}));
    tick();
    txn_no++;
    $display("txn %0d b2b second read rdata=%h at cycle %0d", txn_no, rsp_rdata, n);

    // Reset in the middle of a hung ACCESS phase.
    cfg_waits = 1000;
    req_write = 1'b0; req_addr = 32'h0000_0008; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("rst.pre", 128'({PSEL_UART, PENABLE}), 128'(2'b11));
    #2 PRESETn = 1'b0;
    #1;
    chk("rst.drop", 128'({PSEL_UART, PSEL_GPIO, PENABLE, rsp_valid, req_ready}), 128'(5'b00001));
    chk("rst.regs", 128'({PADDR, PWDATA, PWRITE, rsp_error, rsp_rdata}), 128'(0));
    tick();
    PRESETn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("rst.after", 128'({rsp_valid, req_ready, PSEL_UART}), 128'(3'b010));
      tick();
    end
    txn_no++;
    $display("txn %0d reset mid-ACCESS killed UART read", txn_no);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      case (kind)
        0:       a = {20'h00000, 12'($urandom)};
        1:       a = {20'h00001, 12'($urandom)};
        default: a = {20'($urandom_range(2, 20'hFFFFF)), 12'($urandom)};
      endcase
      wr = 1'($urandom); wd = $urandom; ru = $urandom; rg = $urandom;
      w  = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
      model(wr, a, w, ru, rg, sel, lat, e, r);
      run_cmd("rnd", wr, a, wd, w, ru, rg, sel, lat, e, r);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
